// File: rtl/flight_phase_sequencer.sv
// Flight phase sequencer: steps the altitude/distance integration datapath
// through countdown, vertical ascent, pitch-over and cutoff, with abort and
// controlled-stop handling. All outputs are registered.
module flight_phase_sequencer #(
    parameter int            N               = 64,
    parameter int            COUNTDOWN       = 10,
    parameter logic [N-1:0]  GIMBAL_ALTITUDE = 64'd1_000_000_000_000,
    parameter logic [N-1:0]  TARGET_ALTITUDE = 64'd188_000_000_000_000
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         launch_req,
    input  logic         abort,
    input  logic         altitude_valid,
    input  logic [N-1:0] current_altitude,
    output logic         integrator_clear,
    output logic         altitude_enable,
    output logic         distance_enable,
    output logic         gimbal_enable,
    output logic [2:0]   phase,
    output logic         launch_ack,
    output logic         cutoff
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_ASCENT    = 3'd2,
        ST_PITCH     = 3'd3,
        ST_CUTOFF    = 3'd4,
        ST_ABORT     = 3'd5
    } state_t;

    localparam logic [15:0] COUNT_LAST = 16'(COUNTDOWN - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;

    logic        clear_q, altEn_q, distEn_q, gimbalEn_q, ack_q, cutoff_q;
    logic [2:0]  phase_q;

    logic        reachGimbal, reachTarget;

    // Threshold hits only count on a valid altitude sample.
    always_comb begin
        reachGimbal = altitude_valid && (current_altitude >= GIMBAL_ALTITUDE);
        reachTarget = altitude_valid && (current_altitude >= TARGET_ALTITUDE);
    end

    // Next-state and countdown counter: abort first, then a dropped launch request, then the phase's own rule.
    always_comb begin
        state_d = state_q;
        count_d = 16'd0;
        case (state_q)
            ST_IDLE: begin
                if (launch_req && !abort) begin
                    state_d = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (!launch_req) begin
                    state_d = ST_CUTOFF;
                end else if (count_q == COUNT_LAST) begin
                    state_d = ST_ASCENT;
                end else begin
                    state_d = ST_COUNTDOWN;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end
            end
            ST_ASCENT: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (!launch_req || reachTarget) begin
                    state_d = ST_CUTOFF;
                end else if (reachGimbal) begin
                    state_d = ST_PITCH;
                end
            end
            ST_PITCH: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (!launch_req || reachTarget) begin
                    state_d = ST_CUTOFF;
                end
            end
            ST_CUTOFF: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (!launch_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (!abort && !launch_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and outputs registered together; outputs are decoded from the state being entered.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            count_q    <= 16'd0;
            clear_q    <= 1'b0;
            altEn_q    <= 1'b0;
            distEn_q   <= 1'b0;
            gimbalEn_q <= 1'b0;
            phase_q    <= 3'd0;
            ack_q      <= 1'b0;
            cutoff_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            clear_q    <= (state_d == ST_COUNTDOWN);
            altEn_q    <= (state_d == ST_ASCENT) || (state_d == ST_PITCH);
            distEn_q   <= (state_d == ST_PITCH);
            gimbalEn_q <= (state_d == ST_PITCH);
            phase_q    <= state_d;
            ack_q      <= (state_q == ST_IDLE) && (state_d == ST_COUNTDOWN);
            cutoff_q   <= (state_q != ST_CUTOFF) && (state_d == ST_CUTOFF);
        end
    end

    assign integrator_clear = clear_q;
    assign altitude_enable  = altEn_q;
    assign distance_enable  = distEn_q;
    assign gimbal_enable    = gimbalEn_q;
    assign phase            = phase_q;
    assign launch_ack       = ack_q;
    assign cutoff           = cutoff_q;

endmodule

// File: tb/tb_flight_phase_sequencer.sv
// Testbench for flight_phase_sequencer: directed launch-profile scenarios
// followed by randomized traffic, all checked against a phase-level model.
module tb_flight_phase_sequencer;

    localparam int          CD    = 10;
    localparam logic [63:0] G_ALT = 64'd1_000_000_000_000;
    localparam logic [63:0] T_ALT = 64'd188_000_000_000_000;

    localparam int P_IDLE = 0, P_CD = 1, P_ASC = 2, P_PITCH = 3, P_CUT = 4, P_ABORT = 5;

    logic        clk = 1'b0;
    logic        resetb;
    logic        launchReq, abortIn, altValid;
    logic [63:0] altitude;
    logic        intClear, altEn, distEn, gimbalEn, launchAck, cutoffOut;
    logic [2:0]  phaseOut;

    int checks = 0;
    int failures = 0;

    // Reference model state: current phase and countdown cycles still to run.
    int mPhase;
    int mLeft;
    int mAck;
    int mCut;

    flight_phase_sequencer #(
        .N(64), .COUNTDOWN(CD), .GIMBAL_ALTITUDE(G_ALT), .TARGET_ALTITUDE(T_ALT)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .launch_req(launchReq),
        .abort(abortIn),
        .altitude_valid(altValid),
        .current_altitude(altitude),
        .integrator_clear(intClear),
        .altitude_enable(altEn),
        .distance_enable(distEn),
        .gimbal_enable(gimbalEn),
        .phase(phaseOut),
        .launch_ack(launchAck),
        .cutoff(cutoffOut)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lr, input logic ab, input logic vl, input logic [63:0] alt);
        launchReq = lr;
        abortIn   = ab;
        altValid  = vl;
        altitude  = alt;
    endtask

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic modelStep();
        int prev;
        int nxt;
        prev = mPhase;
        nxt  = prev;
        if (prev == P_IDLE) begin
            if (launchReq && !abortIn) begin
                nxt   = P_CD;
                mLeft = CD;
            end
        end else if (abortIn) begin
            nxt = P_ABORT;
        end else begin
            case (prev)
                P_CD: begin
                    if (!launchReq) nxt = P_CUT;
                    else begin
                        mLeft = mLeft - 1;
                        if (mLeft == 0) nxt = P_ASC;
                    end
                end
                P_ASC: begin
                    if (!launchReq) nxt = P_CUT;
                    else if (altValid && altitude >= T_ALT) nxt = P_CUT;
                    else if (altValid && altitude >= G_ALT) nxt = P_PITCH;
                end
                P_PITCH: begin
                    if (!launchReq) nxt = P_CUT;
                    else if (altValid && altitude >= T_ALT) nxt = P_CUT;
                end
                P_CUT:   if (!launchReq) nxt = P_IDLE;
                P_ABORT: if (!launchReq) nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
        end
        mAck   = (prev == P_IDLE && nxt == P_CD) ? 1 : 0;
        mCut   = (prev != P_CUT && nxt == P_CUT) ? 1 : 0;
        mPhase = nxt;
    endtask

    task automatic modelReset();
        mPhase = P_IDLE;
        mLeft  = 0;
        mAck   = 0;
        mCut   = 0;
    endtask

    task automatic checkAll();
        checkOutput("phase", 64'(phaseOut), 64'(mPhase));
        checkOutput("integrator_clear", 64'(intClear), 64'(mPhase == P_CD));
        checkOutput("altitude_enable", 64'(altEn), 64'(mPhase == P_ASC || mPhase == P_PITCH));
        checkOutput("distance_enable", 64'(distEn), 64'(mPhase == P_PITCH));
        checkOutput("gimbal_enable", 64'(gimbalEn), 64'(mPhase == P_PITCH));
        checkOutput("launch_ack", 64'(launchAck), 64'(mAck));
        checkOutput("cutoff", 64'(cutoffOut), 64'(mCut));
    endtask

    // One clock: edge, model update, check just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Asynchronous reset pulse between clock edges, checked while still asserted.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #1;
        resetb = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_phase"}, 64'(phaseOut), 64'd0);
        checkOutput({tag, "_outs"}, 64'({intClear, altEn, distEn, gimbalEn, launchAck, cutoffOut}), 64'd0);
        #1;
        resetb = 1'b1;
    endtask

    function automatic logic [63:0] pickAltitude();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return G_ALT - 64'd1;
            2: return G_ALT;
            3: return T_ALT - 64'd1;
            4: return T_ALT;
            5: return {$urandom(), $urandom()};
            default: return 64'($urandom());
        endcase
    endfunction

    initial begin
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        resetb = 1'b0;
        #12;
        checkOutput("reset_phase", 64'(phaseOut), 64'd0);
        checkOutput("reset_outs", 64'({intClear, altEn, distEn, gimbalEn, launchAck, cutoffOut}), 64'd0);
        resetb = 1'b1;
        @(negedge clk);

        // Scenario 1: full countdown then vertical ascent.
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        stepCycle();
        checkOutput("s1_ack_cycle1", 64'(launchAck), 64'd1);
        runCycles(9);
        checkOutput("s1_clear_cycle10", 64'(intClear), 64'd1);
        stepCycle();
        checkOutput("s1_alt_en_cycle11", 64'(altEn), 64'd1);

        // Scenario 2: pitch-over exactly at the gimbal threshold.
        applyStimulus(1'b1, 1'b0, 1'b1, G_ALT - 64'd1);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, G_ALT);
        stepCycle();
        checkOutput("s2_pitch", 64'(phaseOut), 64'(P_PITCH));

        // Scenario 3: invalid target sample ignored, valid one cuts off; drop launch to idle.
        applyStimulus(1'b1, 1'b0, 1'b0, T_ALT);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, T_ALT);
        stepCycle();
        checkOutput("s3_cutoff_pulse", 64'(cutoffOut), 64'd1);
        runCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        stepCycle();
        checkOutput("s3_idle", 64'(phaseOut), 64'(P_IDLE));

        // Scenario 4: jump straight past the target from ascent.
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        runCycles(CD + 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'd200_000_000_000_000);
        stepCycle();
        checkOutput("s4_direct_cutoff", 64'(phaseOut), 64'(P_CUT));
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        runCycles(2);

        // Scenario 5: abort beats a simultaneous target crossing in pitch.
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        runCycles(CD + 1);
        applyStimulus(1'b1, 1'b0, 1'b1, G_ALT);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, T_ALT);
        stepCycle();
        checkOutput("s5_abort", 64'(phaseOut), 64'(P_ABORT));
        checkOutput("s5_no_cutoff", 64'(cutoffOut), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        stepCycle();
        checkOutput("s5_idle", 64'(phaseOut), 64'(P_IDLE));

        // Scenario 6: reset mid-countdown and mid-pitch, then a fresh full countdown.
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        runCycles(4);
        pulseReset("s6_cd");
        runCycles(CD + 1);
        applyStimulus(1'b1, 1'b0, 1'b1, G_ALT);
        stepCycle();
        pulseReset("s6_pitch");
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        stepCycle();
        checkOutput("s6_ack", 64'(launchAck), 64'd1);
        runCycles(CD - 1);
        checkOutput("s6_still_cd", 64'(phaseOut), 64'(P_CD));
        stepCycle();
        checkOutput("s6_ascent", 64'(phaseOut), 64'(P_ASC));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), pickAltitude());
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
